// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined adder.
package adder_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Elaboration-time ceiling divide used to size the pipeline.
   function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
      return (num + den - 1) / den;
   endfunction

endpackage

// File: rtl/adder_pipe_if.sv
// Operand/result handshake bundle between source, adder_pipe and consumer.
interface adder_pipe_if #(
   parameter int unsigned WIDTH = 6
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH:0]   s;

   modport master (
      output in_valid, x, y, op, out_ready,
      input  in_ready, out_valid, s
   );

   modport slave (
      input  in_valid, x, y, op, out_ready,
      output in_ready, out_valid, s
   );
endinterface

// File: rtl/adder_chunk.sv
// Combinational W-bit slice adder with carry in/out.
module adder_chunk #(
   parameter int unsigned W = 2
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);
   assign {cout, sum} = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
endmodule

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit add/subtract: one CHUNK-bit ripple slice per register stage,
// with a whole-pipeline freeze when the consumer back-pressures.
module adder_pipe
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = 6,
   parameter int unsigned CHUNK = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   adder_pipe_if.slave  bus
);
   localparam int unsigned STAGES = ceil_div(WIDTH, CHUNK);

   logic stall_c;
   logic accept_c;

   // in_ready follows the stall directly so a draining result frees the slot in the same cycle.
   assign stall_c      = bus.out_valid && !bus.out_ready;
   assign bus.in_ready = !stall_c;
   assign accept_c     = bus.in_valid && !stall_c;

   for (genvar k = 0; k < int'(STAGES); k++) begin : g_stg
      localparam int unsigned LO = k * CHUNK;
      localparam int unsigned CW = (WIDTH - LO < CHUNK) ? (WIDTH - LO) : CHUNK;
      localparam int unsigned HI = LO + CW;

      logic [WIDTH-LO-1:0] a_in;
      logic [WIDTH-LO-1:0] b_in;
      logic                cin;
      logic                v_in;
      logic [CW-1:0]       sum_c;
      logic                cout_c;
      logic [HI-1:0]       sum_n;
      logic [HI-1:0]       sum_q;
      logic                c_q;
      logic                v_q;

      if (k == 0) begin : g_first
         // Subtract is x + ~y + 1; the +1 enters as the stage-0 carry.
         assign a_in  = bus.x;
         assign b_in  = (bus.op == OP_ADD) ? bus.y : ~bus.y;
         assign cin   = (bus.op == OP_SUB);
         assign v_in  = accept_c;
         assign sum_n = sum_c;
      end else begin : g_next
         assign a_in  = g_stg[k-1].g_rem.a_q;
         assign b_in  = g_stg[k-1].g_rem.b_q;
         assign cin   = g_stg[k-1].c_q;
         assign v_in  = g_stg[k-1].v_q;
         assign sum_n = {sum_c, g_stg[k-1].sum_q};
      end

      adder_chunk #(
         .W (CW)
      ) u_chunk (
         .a    (a_in[CW-1:0]),
         .b    (b_in[CW-1:0]),
         .cin  (cin),
         .sum  (sum_c),
         .cout (cout_c)
      );

      // Valid, carry and the lower sum bits produced so far.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q   <= 1'b0;
            c_q   <= 1'b0;
            sum_q <= '0;
         end else if (!stall_c) begin
            v_q   <= v_in;
            c_q   <= cout_c;
            sum_q <= sum_n;
         end
      end

      // Skew registers carry the operand chunks not yet summed.
      if (HI < WIDTH) begin : g_rem
         logic [WIDTH-HI-1:0] a_q;
         logic [WIDTH-HI-1:0] b_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (!stall_c) begin
               a_q <= a_in[WIDTH-LO-1:CW];
               b_q <= b_in[WIDTH-LO-1:CW];
            end
         end
      end
   end

   assign bus.out_valid = g_stg[STAGES-1].v_q;
   assign bus.s         = {g_stg[STAGES-1].c_q, g_stg[STAGES-1].sum_q};

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe: scoreboarded vectors, exhaustive 6-bit adds,
// back-pressure, mid-flight reset and a random sweep over two other geometries.
module tb_adder_pipe;
   import adder_pkg::*;

   typedef struct packed {
      int exp;
      int acc;
   } sb_t;

   typedef struct {
      logic [5:0] x;
      logic [5:0] y;
      logic       op;
      int         exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   bit   lat6 = 1'b1;
   bit   lat7 = 1'b1;
   bit   lat66 = 1'b1;
   sb_t  q6[$];
   sb_t  q7[$];
   sb_t  q66[$];
   vec_t tbl[12];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   adder_pipe_if #(.WIDTH(6)) if6 ();
   adder_pipe_if #(.WIDTH(7)) if7 ();
   adder_pipe_if #(.WIDTH(6)) if66 ();

   adder_pipe #(.WIDTH(6), .CHUNK(2)) u6  (.clk(clk), .rst_n(rst_n), .bus(if6));
   adder_pipe #(.WIDTH(7), .CHUNK(3)) u7  (.clk(clk), .rst_n(rst_n), .bus(if7));
   adder_pipe #(.WIDTH(6), .CHUNK(6)) u66 (.clk(clk), .rst_n(rst_n), .bus(if66));

   function automatic void check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Unsigned reference: add -> plain sum; sub -> wrapped difference plus x>=y flag at bit w.
   function automatic int ref_model(input int w, input int a, input int b, input logic o);
      if (o == OP_ADD) return a + b;
      return ((a - b) & ((1 << w) - 1)) | ((a >= b) ? (1 << w) : 0);
   endfunction

   task automatic monitor();
      sb_t e;
      forever begin
         @(negedge clk);
         if (rst_n && if6.out_valid && if6.out_ready) begin
            check("u6_expected_pending", int'(q6.size() > 0), 1);
            if (q6.size() > 0) begin
               e = q6.pop_front();
               check("u6_s", int'(if6.s), e.exp);
               if (lat6) check("u6_latency", cyc - e.acc, 2);
            end
         end
         if (rst_n && if7.out_valid && if7.out_ready) begin
            check("u7_expected_pending", int'(q7.size() > 0), 1);
            if (q7.size() > 0) begin
               e = q7.pop_front();
               check("u7_s", int'(if7.s), e.exp);
               if (lat7) check("u7_latency", cyc - e.acc, 2);
            end
         end
         if (rst_n && if66.out_valid && if66.out_ready) begin
            check("u66_expected_pending", int'(q66.size() > 0), 1);
            if (q66.size() > 0) begin
               e = q66.pop_front();
               check("u66_s", int'(if66.s), e.exp);
               if (lat66) check("u66_latency", cyc - e.acc, 0);
            end
         end
      end
   endtask

   // Called at posedge+#1; returns at posedge+#1 right after the accepting edge.
   task automatic send6(input logic [5:0] a, input logic [5:0] b, input logic o, input int exp);
      sb_t e;
      bit  ok = 1'b0;
      if6.in_valid = 1'b1;
      if6.x        = a;
      if6.y        = b;
      if6.op       = o;
      for (int t = 0; t < 100 && !ok; t++) begin
         @(negedge clk);
         if (if6.in_ready) begin
            ok    = 1'b1;
            e.exp = exp;
            e.acc = cyc + 1;
            q6.push_back(e);
         end
         @(posedge clk);
         #1;
      end
      if (!ok) check("u6_accept_timeout", int'(ok), 1);
      if6.in_valid = 1'b0;
   endtask

   task automatic drain();
      bit done = 1'b0;
      for (int t = 0; t < 64 && !done; t++) begin
         @(negedge clk);
         done = (q6.size() == 0) && (q7.size() == 0) && (q66.size() == 0);
      end
      check("drain_empty", int'(done), 1);
      @(posedge clk);
      #1;
   endtask

   // Random streams into the 7/3 and 6/6 instances; bp adds random consumer stalls.
   task automatic sweep(input int ncyc, input bit bp);
      sb_t e;
      bit  acc7;
      bit  acc66;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         acc7  = if7.in_valid && if7.in_ready;
         acc66 = if66.in_valid && if66.in_ready;
         if (acc7) begin
            e.exp = ref_model(7, int'(if7.x), int'(if7.y), if7.op);
            e.acc = cyc + 1;
            q7.push_back(e);
         end
         if (acc66) begin
            e.exp = ref_model(6, int'(if66.x), int'(if66.y), if66.op);
            e.acc = cyc + 1;
            q66.push_back(e);
         end
         @(posedge clk);
         #1;
         if (acc7 || !if7.in_valid) begin
            if7.in_valid = ($urandom_range(0, 3) != 0);
            if7.x        = 7'($urandom_range(0, 127));
            if7.y        = 7'($urandom_range(0, 127));
            if7.op       = 1'($urandom_range(0, 1));
         end
         if (acc66 || !if66.in_valid) begin
            if66.in_valid = ($urandom_range(0, 3) != 0);
            if66.x        = 6'($urandom_range(0, 63));
            if66.y        = 6'($urandom_range(0, 63));
            if66.op       = 1'($urandom_range(0, 1));
         end
         if (bp) begin
            if7.out_ready  = ($urandom_range(0, 2) != 0);
            if66.out_ready = ($urandom_range(0, 2) != 0);
         end
      end
      if7.in_valid   = 1'b0;
      if66.in_valid  = 1'b0;
      if7.out_ready  = 1'b1;
      if66.out_ready = 1'b1;
   endtask

   initial begin
      tbl[0]  = '{x: 6'd63, y: 6'd63, op: OP_ADD, exp: 126};
      tbl[1]  = '{x: 6'd5,  y: 6'd7,  op: OP_SUB, exp: 62};
      tbl[2]  = '{x: 6'd7,  y: 6'd5,  op: OP_SUB, exp: 66};
      tbl[3]  = '{x: 6'd0,  y: 6'd0,  op: OP_ADD, exp: 0};
      tbl[4]  = '{x: 6'd0,  y: 6'd0,  op: OP_SUB, exp: 64};
      tbl[5]  = '{x: 6'd63, y: 6'd63, op: OP_SUB, exp: 64};
      tbl[6]  = '{x: 6'd0,  y: 6'd63, op: OP_SUB, exp: 1};
      tbl[7]  = '{x: 6'd32, y: 6'd32, op: OP_ADD, exp: 64};
      tbl[8]  = '{x: 6'd0,  y: 6'd1,  op: OP_SUB, exp: 63};
      tbl[9]  = '{x: 6'd63, y: 6'd1,  op: OP_ADD, exp: 64};
      tbl[10] = '{x: 6'd1,  y: 6'd62, op: OP_ADD, exp: 63};
      tbl[11] = '{x: 6'd40, y: 6'd8,  op: OP_SUB, exp: 96};

      rst_n = 1'b0;
      if6.in_valid  = 1'b0; if6.x  = '0; if6.y  = '0; if6.op  = 1'b0; if6.out_ready  = 1'b1;
      if7.in_valid  = 1'b0; if7.x  = '0; if7.y  = '0; if7.op  = 1'b0; if7.out_ready  = 1'b1;
      if66.in_valid = 1'b0; if66.x = '0; if66.y = '0; if66.op = 1'b0; if66.out_ready = 1'b1;
      fork
         monitor();
      join_none
      #23 rst_n = 1'b1;

      // Reset state of all three instances.
      @(negedge clk);
      check("rst_u6_out_valid",  int'(if6.out_valid), 0);
      check("rst_u6_s",          int'(if6.s), 0);
      check("rst_u6_in_ready",   int'(if6.in_ready), 1);
      check("rst_u7_out_valid",  int'(if7.out_valid), 0);
      check("rst_u7_s",          int'(if7.s), 0);
      check("rst_u7_in_ready",   int'(if7.in_ready), 1);
      check("rst_u66_out_valid", int'(if66.out_valid), 0);
      check("rst_u66_s",         int'(if66.s), 0);
      check("rst_u66_in_ready",  int'(if66.in_ready), 1);
      @(posedge clk);
      #1;

      // Hand-computed vectors, streamed back to back.
      foreach (tbl[i]) send6(tbl[i].x, tbl[i].y, tbl[i].op, tbl[i].exp);
      drain();

      // Every 6-bit add pair, one per cycle.
      for (int i = 0; i < 64; i++)
         for (int j = 0; j < 64; j++)
            send6(6'(i), 6'(j), OP_ADD, ref_model(6, i, j, OP_ADD));
      drain();

      // Back-pressure: consumer stalls for four cycles once results start to emerge.
      lat6 = 1'b0;
      fork
         begin
            for (int i = 1; i <= 4; i++) send6(6'(i), 6'(i), OP_ADD, 2 * i);
         end
         begin
            repeat (3) @(posedge clk);
            #1 if6.out_ready = 1'b0;
            repeat (4) begin
               @(negedge clk);
               check("bp_in_ready", int'(if6.in_ready), 0);
               check("bp_out_valid", int'(if6.out_valid), 1);
               check("bp_s_hold", int'(if6.s), 2);
            end
            @(posedge clk);
            #1 if6.out_ready = 1'b1;
         end
      join
      drain();
      lat6 = 1'b1;

      // Reset with three operations in flight; nothing may emerge afterwards.
      if6.out_ready = 1'b0;
      send6(6'd10, 6'd1, OP_ADD, 11);
      send6(6'd20, 6'd2, OP_ADD, 22);
      send6(6'd30, 6'd3, OP_ADD, 33);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", int'(if6.out_valid), 0);
      check("midrst_s", int'(if6.s), 0);
      q6.delete();
      #3 rst_n = 1'b1;
      if6.out_ready = 1'b1;
      repeat (8) begin
         @(negedge clk);
         check("midrst_no_stale", int'(if6.out_valid), 0);
      end
      @(posedge clk);
      #1;

      // Other geometries: free-flowing with latency checks, then with random stalls.
      sweep(400, 1'b0);
      drain();
      lat7  = 1'b0;
      lat66 = 1'b0;
      sweep(400, 1'b1);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
- Parametrised, pipelined successor to the 6-bit combinational adder (x + y -> 7-bit s).
- Splits a WIDTH-bit add/subtract into CHUNK-bit carry-ripple stages, one register stage per chunk.
- Valid/ready handshake on input and output; sustains one operation per cycle when not back-pressured.
- Sits between an operand source and a result consumer; the existing exhaustive 6-bit vector file remains usable with WIDTH=6.

Parameters:
- WIDTH, 6, operand width in bits; must be >= 1.
- CHUNK, 2, bits summed per pipeline stage; 1 <= CHUNK <= WIDTH.
- STAGES, derived, ceil(WIDTH/CHUNK); local, not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and op present
- in_ready  out  1  block accepts operands this cycle
- x  in  WIDTH  operand A
- y  in  WIDTH  operand B
- op  in  1  0 = add (x+y), 1 = subtract (x-y)
- out_valid  out  1  s holds a valid result
- out_ready  in  1  consumer takes the result this cycle
- s  out  WIDTH+1  result; s[WIDTH] = carry-out (add) or no-borrow flag (sub)

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits = 0, out_valid = 0, s = 0, all internal carries = 0. in_ready = 1 once rst_n is high. Reset mid-operation discards every in-flight operation; nothing emerges afterwards.
- Accept: a transfer occurs when in_valid && in_ready.
- Stall: stall = out_valid && !out_ready. in_ready = !stall.
  - While stall is high, every pipeline register holds its value and s stays stable.
  - Bubbles are not compressed during a stall; the whole pipeline freezes.
- Latency:
  - An operation accepted at edge N appears with out_valid = 1 after edge N+STAGES-1 when no stall occurs. For WIDTH=6, CHUNK=2, result is visible after the 3rd edge.
  - Stall cycles add one cycle each.
- Throughput: one result per cycle with out_ready held at 1.
- Arithmetic:
  - Stage 0 uses effective B = op ? ~y : y, with carry-in = op.
  - Stage k sums chunk k of x and chunk k of effective B plus the carry registered from stage k-1.
  - Unprocessed upper operand chunks and already-computed lower sum chunks are carried forward in skew registers.
  - The last chunk may be narrower (WIDTH mod CHUNK). Its carry-out becomes s[WIDTH].
  - Result is exactly {carry, (x + B + op) mod 2^WIDTH}, with no saturation.
  - Subtract: s[WIDTH] = 1 iff x >= y (unsigned).
- Wrap-around: add overflow is reported only via s[WIDTH]; the lower bits wrap modulo 2^WIDTH.
- Simultaneous events:
  - A result leaving while a new operand enters in the same cycle is legal and required.
  - in_valid while in_ready = 0 has no effect; the source must hold its operands.
- Degenerate STAGES=1 (CHUNK >= WIDTH): a single registered adder with latency 1; the handshake rules are unchanged.

Decomposition:
- Shared package adder_pkg holds: OP_ADD = 1'b0, OP_SUB = 1'b1, and a ceil-divide function used to compute STAGES.
- Sub-module adder_chunk: a combinational CHUNK-bit adder (a, b, cin -> sum, cout), instantiated once per stage by a generate loop.
- Pipeline registers, skew registers and the valid/stall logic live in adder_pipe.

Test Plan:
- WIDTH=6, CHUNK=2: x=63, y=63, op=0, out_ready=1 -> out_valid rises 3 cycles later, s = 7'b1111110 (126).
- Subtract: x=5, y=7, op=1 -> s = 7'b0111110 (62, no-borrow = 0). x=7, y=5, op=1 -> s = 7'b1000010 (2, no-borrow = 1).
- Exhaustive: all 4096 (x,y) add pairs back-to-back from the existing 6-bit vector file, with out_ready=1 -> every result matches and exactly one result appears per cycle after the 3-cycle fill.
- Back-pressure: stream 1+1, 2+2, 3+3, 4+4 and drop out_ready for 4 cycles mid-stream -> in_ready = 0 during the stall, s stays constant, outputs 2, 4, 6, 8 in order with no loss or duplication.
- Reset mid-flight: 3 operations in flight, pulse rst_n low between edges -> out_valid = 0 and s = 0 immediately; no stale result appears afterwards.
- Parameter sweep: WIDTH=7, CHUNK=3 (narrow last chunk) and WIDTH=6, CHUNK=6, using random operands checked against a reference model -> 0 mismatches; latency is 3 and 1 cycles respectively.
